// File: rtl/immgen_pkg.sv
// Shared immediate-type codes and RISC-V major opcodes for the ID immediate generator.
package immgen_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_NONE = 3'b111
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/id_immgen_pipe_imm_decode.sv
// Combinational immediate decoder: instruction word -> extended immediate, type, illegal flag.
// Optional CSR-immediate (Z type) decoding is enabled by defining IMMGEN_ZICSR_EN.
module imm_decode
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm,
  output imm_type_e       o_immtype,
  output logic            o_illegal
);

  logic [6:0] w_op;
  logic [2:0] w_f3;
  logic       w_sign;

  assign w_op   = i_inst[6:0];
  assign w_f3   = i_inst[14:12];
  assign w_sign = i_inst[31];

  always_comb begin
    o_imm     = '0;
    o_immtype = IMM_NONE;
    o_illegal = 1'b0;
    case (w_op)
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR: begin
        if (w_op == OP_IMM32 && XLEN == 32) begin
          o_illegal = 1'b1;
        end else begin
          o_immtype = IMM_I;
          // Shift-immediates carry a zero-extended shamt, 6 bits only for 64-bit OP_IMM.
          if ((w_op == OP_IMM || w_op == OP_IMM32) && w_f3[1:0] == 2'b01) begin
            if (XLEN == 64 && w_op == OP_IMM) o_imm = {{(XLEN-6){1'b0}}, i_inst[25:20]};
            else                              o_imm = {{(XLEN-5){1'b0}}, i_inst[24:20]};
          end else begin
            o_imm = {{(XLEN-12){w_sign}}, i_inst[31:20]};
          end
        end
      end
      OP_STORE: begin
        o_immtype = IMM_S;
        o_imm     = {{(XLEN-12){w_sign}}, i_inst[31:25], i_inst[11:7]};
      end
      OP_BRANCH: begin
        o_immtype = IMM_B;
        o_imm     = {{(XLEN-13){w_sign}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        o_immtype = IMM_U;
        o_imm     = {{(XLEN-32){w_sign}}, i_inst[31:12], 12'h000};
      end
      OP_JAL: begin
        o_immtype = IMM_J;
        o_imm     = {{(XLEN-21){w_sign}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      OP_REG: begin
        o_immtype = IMM_NONE;
      end
      OP_REG32: begin
        o_illegal = (XLEN == 32);
      end
      OP_SYSTEM: begin
`ifdef IMMGEN_ZICSR_EN
        if (w_f3[2]) begin
          o_immtype = IMM_Z;
          o_imm     = {{(XLEN-5){1'b0}}, i_inst[19:15]};
        end
`else
        o_immtype = IMM_NONE;
`endif
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_immgen_pipe.sv
// Decode-stage immediate generator: one-cycle pipe with an output register plus one skid entry.
// XLEN must be 32 or 64; decoding of CSR immediates follows IMMGEN_ZICSR_EN (see imm_decode).
module id_immgen_pipe
  import immgen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_immtype,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  // Stage p0: combinational decode of the incoming instruction
  logic [XLEN-1:0] w_imm_p0;
  imm_type_e       w_type_p0;
  logic            w_ill_p0;
  logic            w_acc_p0;
  logic            w_out_free_p0;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_inst    (in_inst),
    .o_imm     (w_imm_p0),
    .o_immtype (w_type_p0),
    .o_illegal (w_ill_p0)
  );

  // Stage p1: output register and skid entry
  logic            r_vld_p1;
  logic [XLEN-1:0] r_imm_p1;
  imm_type_e       r_type_p1;
  logic [31:0]     r_inst_p1;
  logic [XLEN-1:0] r_pc_p1;
  logic            r_ill_p1;

  logic            r_skid_vld_p1;
  logic [XLEN-1:0] r_skid_imm_p1;
  imm_type_e       r_skid_type_p1;
  logic [31:0]     r_skid_inst_p1;
  logic [XLEN-1:0] r_skid_pc_p1;
  logic            r_skid_ill_p1;

  assign in_ready      = ~r_skid_vld_p1;
  assign w_acc_p0      = in_valid & ~r_skid_vld_p1;
  assign w_out_free_p0 = ~r_vld_p1 | out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_imm_p1      <= '0;
      r_type_p1     <= IMM_NONE;
      r_inst_p1     <= '0;
      r_pc_p1       <= '0;
      r_ill_p1      <= 1'b0;
    end else if (flush) begin
      r_vld_p1      <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
    end else if (w_out_free_p0) begin
      // Skid holds the older entry, so it always drains first; no accept can occur while it is full.
      if (r_skid_vld_p1) begin
        r_vld_p1      <= 1'b1;
        r_skid_vld_p1 <= 1'b0;
        r_imm_p1      <= r_skid_imm_p1;
        r_type_p1     <= r_skid_type_p1;
        r_inst_p1     <= r_skid_inst_p1;
        r_pc_p1       <= r_skid_pc_p1;
        r_ill_p1      <= r_skid_ill_p1;
      end else if (w_acc_p0) begin
        r_vld_p1      <= 1'b1;
        r_imm_p1      <= w_imm_p0;
        r_type_p1     <= w_type_p0;
        r_inst_p1     <= in_inst;
        r_pc_p1       <= in_pc;
        r_ill_p1      <= w_ill_p0;
      end else begin
        r_vld_p1      <= 1'b0;
      end
    end else if (w_acc_p0) begin
      r_skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && !w_out_free_p0 && w_acc_p0) begin
      r_skid_imm_p1  <= w_imm_p0;
      r_skid_type_p1 <= w_type_p0;
      r_skid_inst_p1 <= in_inst;
      r_skid_pc_p1   <= in_pc;
      r_skid_ill_p1  <= w_ill_p0;
    end
  end

  assign out_valid   = r_vld_p1;
  assign out_imm     = r_imm_p1;
  assign out_immtype = r_type_p1;
  assign out_inst    = r_inst_p1;
  assign out_pc      = r_pc_p1;
  assign out_illegal = r_ill_p1;

endmodule

// File: tb/tb_id_immgen_pipe.sv
// Self-checking bench: 32- and 64-bit instances share stimulus; vector table, handshake corners, random vs model.
module tb_id_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        rdy32, vld32, ill32;
  logic [31:0] imm32, inst32, pc32;
  logic [2:0]  ty32;
  logic        rdy64, vld64, ill64;
  logic [63:0] imm64, pc64;
  logic [31:0] inst64;
  logic [2:0]  ty64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_immgen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_immtype(ty32), .out_inst(inst32), .out_pc(pc32), .out_illegal(ill32)
  );

  id_immgen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_immtype(ty64), .out_inst(inst64), .out_pc(pc64), .out_illegal(ill64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] e32;
    logic [63:0] e64;
    logic [2:0]  t32;
    logic [2:0]  t64;
    logic        il32;
    logic        il64;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
  } ent_t;

  vec_t vt[12];
  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference decode from the instruction-set rules, using signed arithmetic on the fields.
  function automatic void ref_dec(input logic [31:0] in, input int xl,
                                  output logic [63:0] imm, output logic [2:0] ty, output logic il);
    logic [6:0] op;
    logic [2:0] f3;
    longint     v;
    op = in[6:0];
    f3 = in[14:12];
    v  = 0;
    ty = 3'b111;
    il = 1'b0;
    case (op)
      7'h13, 7'h03, 7'h67, 7'h1B: begin
        if (op == 7'h1B && xl == 32) il = 1'b1;
        else begin
          ty = 3'b000;
          if ((op == 7'h13 || op == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5))
            v = (xl == 64 && op == 7'h13) ? longint'(in[25:20]) : longint'(in[24:20]);
          else
            v = longint'($signed(in[31:20]));
        end
      end
      7'h23: begin ty = 3'b001; v = longint'($signed({in[31:25], in[11:7]})); end
      7'h63: begin ty = 3'b010; v = longint'($signed({in[31], in[7], in[30:25], in[11:8]})) * 2; end
      7'h37, 7'h17: begin ty = 3'b011; v = longint'($signed(in[31:12])) * 4096; end
      7'h6F: begin ty = 3'b100; v = longint'($signed({in[31], in[19:12], in[20], in[30:21]})) * 2; end
      7'h33: ty = 3'b111;
      7'h3B: il = (xl == 32);
      7'h73: begin
`ifdef IMMGEN_ZICSR_EN
        if (f3[2]) begin ty = 3'b101; v = longint'(in[19:15]); end
`endif
      end
      default: il = 1'b1;
    endcase
    imm = (xl == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  task automatic chk_model_out(input string nm, input ent_t e);
    logic [63:0] m;
    logic [2:0]  t;
    logic        il;
    ref_dec(e.inst, 32, m, t, il);
    chk({nm, "_imm32"}, {32'h0, imm32}, m);
    chk({nm, "_ty32"}, {61'h0, ty32}, {61'h0, t});
    chk({nm, "_ill32"}, {63'h0, ill32}, {63'h0, il});
    chk({nm, "_inst32"}, {32'h0, inst32}, {32'h0, e.inst});
    chk({nm, "_pc32"}, {32'h0, pc32}, {32'h0, e.pc[31:0]});
    ref_dec(e.inst, 64, m, t, il);
    chk({nm, "_imm64"}, imm64, m);
    chk({nm, "_ty64"}, {61'h0, ty64}, {61'h0, t});
    chk({nm, "_ill64"}, {63'h0, ill64}, {63'h0, il});
    chk({nm, "_pc64"}, pc64, e.pc);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0]  ops[14];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h3B, 7'h73, 7'h7F, 7'h00};
    r = $urandom;
    if (r[3:0] == 4'd13) return $urandom;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  initial begin
    vt[0]  = '{32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd0, 3'd0, 1'b0, 1'b0};
    vt[1]  = '{32'h123450B7, 64'h12345000, 64'h00000000_12345000, 3'd3, 3'd3, 1'b0, 1'b0};
    vt[2]  = '{32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0};
    vt[3]  = '{32'h0080006F, 64'h00000008, 64'h00000000_00000008, 3'd4, 3'd4, 1'b0, 1'b0};
    vt[4]  = '{32'h0000007F, 64'h0, 64'h0, 3'd7, 3'd7, 1'b1, 1'b1};
`ifdef IMMGEN_ZICSR_EN
    vt[5]  = '{32'h3002D073, 64'h5, 64'h5, 3'd5, 3'd5, 1'b0, 1'b0};
`else
    vt[5]  = '{32'h3002D073, 64'h0, 64'h0, 3'd7, 3'd7, 1'b0, 1'b0};
`endif
    vt[6]  = '{32'h00209093, 64'h2, 64'h2, 3'd0, 3'd0, 1'b0, 1'b0};
    vt[7]  = '{32'h4210D093, 64'h1, 64'h21, 3'd0, 3'd0, 1'b0, 1'b0};
    vt[8]  = '{32'hFE20AC23, 64'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd1, 3'd1, 1'b0, 1'b0};
    vt[9]  = '{32'h002081B3, 64'h0, 64'h0, 3'd7, 3'd7, 1'b0, 1'b0};
    vt[10] = '{32'h0010009B, 64'h0, 64'h1, 3'd7, 3'd0, 1'b1, 1'b0};
    vt[11] = '{32'h800000B7, 64'h80000000, 64'hFFFFFFFF_80000000, 3'd3, 3'd3, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0;
    step(); step();
    chk("rst_vld", {63'h0, vld32}, 64'h0);
    chk("rst_rdy", {63'h0, rdy32}, 64'h1);
    chk("rst_imm", {32'h0, imm32}, 64'h0);
    chk("rst_ty", {61'h0, ty32}, 64'h7);
    chk("rst_inst", {32'h0, inst32}, 64'h0);
    chk("rst_pc", {32'h0, pc32}, 64'h0);
    chk("rst_ill", {63'h0, ill32}, 64'h0);
    chk("rst_imm64", imm64, 64'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();

    // Back-to-back vectors, each visible one cycle after acceptance
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_inst  = vt[i].inst;
      in_pc    = 64'hABCD_0000_0000_1000 + 64'(4 * i);
      step();
      chk($sformatf("vec%0d_vld", i), {62'h0, vld32, vld64}, 64'h3);
      chk($sformatf("vec%0d_imm32", i), {32'h0, imm32}, vt[i].e32);
      chk($sformatf("vec%0d_imm64", i), imm64, vt[i].e64);
      chk($sformatf("vec%0d_ty", i), {58'h0, ty32, ty64}, {58'h0, vt[i].t32, vt[i].t64});
      chk($sformatf("vec%0d_ill", i), {62'h0, ill32, ill64}, {62'h0, vt[i].il32, vt[i].il64});
      chk($sformatf("vec%0d_inst", i), {inst32, inst64}, {vt[i].inst, vt[i].inst});
      chk($sformatf("vec%0d_pc", i), pc64, in_pc);
      chk($sformatf("vec%0d_rdy", i), {63'h0, rdy32}, 64'h1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_vld", {63'h0, vld32}, 64'h0);

    // Stall: A in output, B in skid, C held off until release
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 64'h100;
    step();
    chk("st_a_vld", {63'h0, vld32}, 64'h1);
    chk("st_a_rdy", {63'h0, rdy32}, 64'h1);
    in_inst = 32'h00200093; in_pc = 64'h104;
    step();
    chk("st_b_inst", {32'h0, inst32}, 64'h00100093);
    chk("st_b_rdy", {63'h0, rdy32}, 64'h0);
    in_inst = 32'h00300093; in_pc = 64'h108;
    step();
    chk("st_c_inst", {32'h0, inst32}, 64'h00100093);
    chk("st_c_rdy", {62'h0, rdy32, rdy64}, 64'h0);
    out_ready = 1'b1;
    step();
    chk("rel_b_inst", {32'h0, inst32}, 64'h00200093);
    chk("rel_b_imm", {32'h0, imm32}, 64'h2);
    chk("rel_b_rdy", {63'h0, rdy32}, 64'h1);
    step();
    chk("rel_c_inst", {32'h0, inst32}, 64'h00300093);
    chk("rel_c_pc", pc64, 64'h108);
    in_valid = 1'b0;
    step();
    chk("rel_empty", {63'h0, vld32}, 64'h0);

    // Flush with both entries full and input offered
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00400093;
    step();
    in_inst = 32'h00500093;
    step();
    flush = 1'b1; in_inst = 32'h00600093;
    step();
    chk("fl_full_vld", {62'h0, vld32, vld64}, 64'h0);
    chk("fl_full_rdy", {62'h0, rdy32, rdy64}, 64'h3);
    // Flush with only the output full, so the offered input would otherwise be accepted
    flush = 1'b0; in_inst = 32'h00700093;
    step();
    flush = 1'b1; in_inst = 32'h00800093;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_half_vld", {63'h0, vld32}, 64'h0);
    step();
    chk("fl_dropped", {63'h0, vld32}, 64'h0);

    // Reset mid-stall outranks flush and handshakes
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'hFFF00093;
    step(); step();
    rst = 1'b1; flush = 1'b1;
    step();
    chk("rst_mid_vld", {63'h0, vld32}, 64'h0);
    chk("rst_mid_rdy", {63'h0, rdy32}, 64'h1);
    chk("rst_mid_imm", {32'h0, imm32}, 64'h0);
    chk("rst_mid_ty", {61'h0, ty64}, 64'h7);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    q.delete();

    // Random traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      ent_t e;
      bit   acc, cons;
      chk("rnd_vld32", {63'h0, vld32}, {63'h0, q.size() > 0});
      chk("rnd_vld64", {63'h0, vld64}, {63'h0, q.size() > 0});
      chk("rnd_rdy", {62'h0, rdy32, rdy64}, (q.size() < 2) ? 64'h3 : 64'h0);
      if (q.size() > 0) chk_model_out("rnd", q[0]);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      if (flush) begin
        q.delete();
      end else begin
        cons = (q.size() > 0) && out_ready;
        acc  = in_valid && (q.size() < 2);
        if (cons) void'(q.pop_front());
        if (acc) begin
          e.inst = in_inst;
          e.pc   = in_pc;
          q.push_back(e);
        end
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_immgen_pipe.md
ID_IMMGEN_PIPE -- requirements
Module: id_immgen_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64 only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 flush  input  1  drop all buffered entries (branch redirect).
REQ-005 in_valid  input  1  upstream holds a valid instruction.
REQ-006 in_ready  output  1  block accepts in_inst/in_pc this cycle.
REQ-007 in_inst  input  32  raw instruction word.
REQ-008 in_pc  input  XLEN  PC of in_inst.
REQ-009 out_valid  output  1  out_* fields hold a valid entry.
REQ-010 out_ready  input  1  downstream consumes the entry this cycle.
REQ-011 out_imm  output  XLEN  decoded, extended immediate.
REQ-012 out_immtype  output  3  I=000 S=001 B=010 U=011 J=100 Z=101 NONE=111.
REQ-013 out_inst / out_pc  output  32 / XLEN  instruction and PC passed through unchanged.
REQ-014 out_illegal  output  1  opcode not recognised.

Function
REQ-015 Transfer in on in_valid&in_ready; out on out_valid&out_ready.
REQ-016 Type derived from inst[6:0] internally: 0010011,0000011,1100111,0011011(XLEN=64 only) -> I; 0100011 -> S; 1100011 -> B; 0110111,0010111 -> U; 1101111 -> J; 0110011,0111011(XLEN=64 only) -> NONE, imm 0.
REQ-017 Any other opcode -> type NONE, imm 0, out_illegal=1; entry still flows through the pipe.
REQ-018 I/S/B/U/J bit fields per RV32I base encodings; B and J bit0=0; U low 12 bits 0.
REQ-019 All types except Z and shifts sign-extend from inst[31] to XLEN; U on XLEN=64 sign-extends bit 31 into [63:32].
REQ-020 Shift-immediate (opcode 0010011 or 0011011, funct3 001/101): imm = shamt zero-extended; shamt = inst[24:20] (XLEN=32 or opcode 0011011), inst[25:20] (XLEN=64, 0010011).
REQ-021 Latency exactly 1 cycle: entry accepted at edge N visible at out_* after edge N when buffer was empty.
REQ-022 Storage: main output register plus one skid entry; throughput 1/cycle with out_ready high.
REQ-023 in_ready is registered: 1 iff skid entry empty; asserted regardless of out_ready.
REQ-024 Stall (out_valid&!out_ready) with input accepted: new entry goes to skid; when out drains, skid moves to output next edge; order strictly FIFO.
REQ-025 Simultaneous accept and consume with empty skid: output register reloads with new entry, no bubble.
REQ-026 flush: both entries invalidated at that edge; input offered the same cycle dropped; out_valid=0 and in_ready=1 after the edge; flush beats in/out handshakes.
REQ-027 out_* data fields hold last value while out_valid=0; verification checks them only when out_valid=1.

Reset
REQ-028 rst at edge: out_valid=0, skid empty, in_ready=1, out_imm=0, out_immtype=111, out_inst=0, out_pc=0, out_illegal=0.
REQ-029 rst mid-stall discards all entries; rst has priority over flush and handshakes.

Configuration
REQ-030 Macro IMMGEN_ZICSR_EN: when defined, opcode 1110011 with funct3[2]=1 -> type Z, imm = inst[19:15] zero-extended; funct3[2]=0 -> type NONE, imm 0; not illegal.
REQ-031 Without IMMGEN_ZICSR_EN: opcode 1110011 -> type NONE, imm 0, out_illegal=0; code 101 never produced.

Structure
REQ-032 Shared package immgen_pkg: immtype codes, opcode constants, imm-type enum typedef.
REQ-033 Sub-module imm_decode: purely combinational (inst -> imm, immtype, illegal), instantiated once at the input side; pipe control in top.

Verification
REQ-034 XLEN=32: 0xFFF00093 (addi x1,x0,-1) -> next cycle out_imm 0xFFFFFFFF, type 000; 0x123450B7 (lui) -> 0x12345000, type 011.
REQ-035 0xFE000EE3 (beq -4) -> 0xFFFFFFFC type 010; 0x0080006F (jal +8) -> 0x00000008 type 100; XLEN=64 addi -1 -> 0xFFFFFFFFFFFFFFFF.
REQ-036 out_ready=0 for 3 cycles, in_valid=1 with A,B,C: A,B held, in_ready=0 after B, C stalled; release -> A,B,C in order, no loss.
REQ-037 Both entries full, flush=1 with in_valid=1 -> out_valid=0, in_ready=1 next cycle; flushed-cycle input never appears.
REQ-038 0x3002D073 (csrrwi 0x300,5): with IMMGEN_ZICSR_EN -> imm 5 type 101; without -> imm 0 type 111; 0x0000007F -> out_illegal=1.
